led_pattern_gen: RTL

Parametrised LED pattern engine. It is the next generation of the fixed 4-LED blinker that `top` currently drives.
- Generalised in LED count, step rate and PWM depth.
- Run-time selectable modes: off, blink, chase and breathe.
- Sits directly behind `top`: `top` ties `mode`/`en` to constants or switches and connects `led` to the board pins.

---
 rtl/led_pkg.sv | 14 +
 rtl/led_pattern_gen_tick_gen.sv | 33 +++
 rtl/led_pattern_gen.sv | 112 +++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and default constants for the LED pattern engine.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    localparam int unsigned TICK_DIV_DEF = 50_000_000;
    localparam int unsigned PWM_BITS_DEF = 8;

endpackage

// File: rtl/led_pattern_gen_tick_gen.sv
// Pattern-step prescaler: one-cycle strobe every TICK_DIV enabled cycles.
module tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] div_cnt;

    // clr restarts a full period and swallows a coincident strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (clr) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (en) begin
            tick    <= (div_cnt == LAST);
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + CW'(1);
        end else begin
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Run-time selectable LED pattern engine: off, blink, chase and PWM breathe.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int unsigned N_LED    = 4,
    parameter int unsigned TICK_DIV = TICK_DIV_DEF,
    parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [N_LED-1:0] led,
    output logic             tick
);

    localparam logic [PWM_BITS-1:0] MAX = '1;

    mode_e               mode_q;
    logic [N_LED-1:0]    chase;
    logic                blink_q;
    logic [PWM_BITS-1:0] duty;
    logic                dir_down;
    logic [PWM_BITS-1:0] pwm_cnt;

    logic                mode_chg_c;
    logic [PWM_BITS-1:0] duty_nxt_c;
    logic                dir_down_nxt_c;

    assign mode_chg_c = (mode_e'(mode) != mode_q);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (mode_chg_c),
        .tick  (tick)
    );

    // Triangle ramp 0..MAX..0; endpoints turn around without repeating
    always_comb begin
        duty_nxt_c     = duty;
        dir_down_nxt_c = dir_down;
        if (!dir_down) begin
            if (duty == MAX) begin
                dir_down_nxt_c = 1'b1;
                duty_nxt_c     = MAX - PWM_BITS'(1);
            end else begin
                duty_nxt_c     = duty + PWM_BITS'(1);
            end
        end else begin
            if (duty == '0) begin
                dir_down_nxt_c = 1'b0;
                duty_nxt_c     = PWM_BITS'(1);
            end else begin
                duty_nxt_c     = duty - PWM_BITS'(1);
            end
        end
    end

    // Pattern state: a mode change restarts every pattern from its initial state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_OFF;
            chase    <= N_LED'(1);
            blink_q  <= 1'b0;
            duty     <= '0;
            dir_down <= 1'b0;
            pwm_cnt  <= '0;
        end else begin
            mode_q <= mode_e'(mode);
            if (mode_chg_c) begin
                chase    <= N_LED'(1);
                blink_q  <= 1'b0;
                duty     <= '0;
                dir_down <= 1'b0;
                pwm_cnt  <= '0;
            end else if (en) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
                if (tick) begin
                    case (mode_q)
                        MODE_BLINK:   blink_q <= ~blink_q;
                        MODE_CHASE:   chase   <= {chase[N_LED-2:0], chase[N_LED-1]};
                        MODE_BREATHE: begin
                            duty     <= duty_nxt_c;
                            dir_down <= dir_down_nxt_c;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // LED drive lags the pattern state by one cycle and holds while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
        end else if (en) begin
            case (mode_q)
                MODE_OFF:     led <= '0;
                MODE_BLINK:   led <= {N_LED{blink_q}};
                MODE_CHASE:   led <= chase;
                MODE_BREATHE: led <= {N_LED{pwm_cnt < duty}};
                default:      led <= '0;
            endcase
        end
    end

endmodule
